// File: rtl/b1_pkg.sv
`default_nettype none
// ============================================================
// Package : b1_pkg
// Brief   : Shared constants and tap helper for the B1 code generator.
// Rev     : 1.0
// ============================================================
package b1_pkg;

  localparam int unsigned c_code_len  = 2046;
  // Stage k of each LFSR lives in bit k-1; feedback into stage 1.
  localparam logic [10:0] c_lfsr_init = 11'b010_1010_1010;
  localparam logic [10:0] c_g1_mask   = 11'b111_1100_0001;
  localparam logic [10:0] c_g2_mask   = 11'b101_1001_1111;

  // Returns stage t (1..11) of an LFSR; out-of-range selects read as 0.
  function automatic logic f_lfsr_tap(input logic [10:0] r, input logic [3:0] t);
    logic b;
    b = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      if (t == k[3:0]) b = r[k-1];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/b1_gold_lfsr.sv
`default_nettype none
// ============================================================
// Module  : b1_gold_lfsr
// Brief   : G1/G2 Gold-code pair with truncated period and tap mux.
// Rev     : 1.0
// ============================================================
module b1_gold_lfsr
  import b1_pkg::*;
#(
  parameter int unsigned CODE_LEN = c_code_len
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tick,
  input  logic        i_half,
  input  logic [3:0]  i_tap1,
  input  logic [3:0]  i_tap2,
  output logic        o_code,
  output logic [10:0] o_chip
);

  localparam logic [10:0] c_last = 11'(CODE_LEN - 1);

  logic [10:0] r_g1;
  logic [10:0] r_g2;
  logic [10:0] r_chip;
  logic [3:0]  r_tap1;
  logic [3:0]  r_tap2;
  logic        r_lock;
  logic        w_adv;
  logic        w_fb1;
  logic        w_fb2;

  assign w_adv = i_tick & i_half;
  assign w_fb1 = ^(r_g1 & c_g1_mask);
  assign w_fb2 = ^(r_g2 & c_g2_mask);

  // Taps follow the inputs until the first tick, then only move at chip boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_g1   <= c_lfsr_init;
      r_g2   <= c_lfsr_init;
      r_chip <= 11'd0;
      r_tap1 <= 4'd0;
      r_tap2 <= 4'd0;
      r_lock <= 1'b0;
    end else begin
      if (!r_lock || w_adv) begin
        r_tap1 <= i_tap1;
        r_tap2 <= i_tap2;
      end
      if (i_tick) r_lock <= 1'b1;
      if (w_adv) begin
        if (r_chip == c_last) begin
          r_g1   <= c_lfsr_init;
          r_g2   <= c_lfsr_init;
          r_chip <= 11'd0;
        end else begin
          r_g1   <= {r_g1[9:0], w_fb1};
          r_g2   <= {r_g2[9:0], w_fb2};
          r_chip <= r_chip + 11'd1;
        end
      end
    end
  end

  assign o_code = r_g1[10] ^ f_lfsr_tap(r_g2, r_tap1) ^ f_lfsr_tap(r_g2, r_tap2);
  assign o_chip = r_chip;

endmodule
`default_nettype wire

// File: rtl/b1_code_gen.sv
`default_nettype none
// ============================================================
// Module  : b1_code_gen
// Brief   : NCO-driven B1 replica generator, E/P/L at half-chip spacing.
//           Define B1_BOC_SUBCARRIER_EN for BOC(1,1) replicas, else BPSK.
// Rev     : 1.0
// ============================================================
module b1_code_gen
  import b1_pkg::*;
#(
  parameter int unsigned CODE_LEN = c_code_len,
  parameter int unsigned NCO_W    = 32
) (
  input  logic             rx_clk,
  input  logic             rx_rst,
  input  logic             rx_en,
  input  logic [NCO_W-1:0] rx_prn_fcw,
  input  logic [3:0]       rx_g2_tap1,
  input  logic [3:0]       rx_g2_tap2,
  output logic             tx_loc_bocE,
  output logic             tx_loc_bocP,
  output logic             tx_loc_bocL,
  output logic             tx_prn_sop,
  output logic [10:0]      tx_chip_idx
);

  logic [NCO_W-1:0] r_acc;
  logic             r_half;
  logic             r_e;
  logic             r_p;
  logic             r_l;
  logic [10:0]      r_e_idx;
  logic [10:0]      r_p_idx;
  logic             r_e_half;
  logic             r_e_vld;
  logic             r_sop;
  logic [NCO_W:0]   w_sum;
  logic             w_tick;
  logic             w_code;
  logic             w_early;
  logic [10:0]      w_chip;

  assign w_sum  = {1'b0, r_acc} + {1'b0, rx_prn_fcw};
  assign w_tick = rx_en & w_sum[NCO_W];

`ifdef B1_BOC_SUBCARRIER_EN
  assign w_early = w_code ^ r_half;
`else
  assign w_early = w_code;
`endif

  b1_gold_lfsr #(
    .CODE_LEN (CODE_LEN)
  ) u_lfsr (
    .clk    (rx_clk),
    .rst    (rx_rst),
    .i_tick (w_tick),
    .i_half (r_half),
    .i_tap1 (rx_g2_tap1),
    .i_tap2 (rx_g2_tap2),
    .o_code (w_code),
    .o_chip (w_chip)
  );

  // Early carries its own (chip, half) tag so Prompt's index and the
  // start-of-period strobe line up with the sample actually in Prompt.
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      r_acc    <= '0;
      r_half   <= 1'b0;
      r_e      <= 1'b0;
      r_p      <= 1'b0;
      r_l      <= 1'b0;
      r_e_idx  <= 11'd0;
      r_p_idx  <= 11'd0;
      r_e_half <= 1'b0;
      r_e_vld  <= 1'b0;
      r_sop    <= 1'b0;
    end else begin
      if (rx_en) r_acc <= w_sum[NCO_W-1:0];
      r_sop <= w_tick & r_e_vld & (r_e_idx == 11'd0) & ~r_e_half;
      if (w_tick) begin
        r_e      <= w_early;
        r_p      <= r_e;
        r_l      <= r_p;
        r_e_idx  <= w_chip;
        r_p_idx  <= r_e_idx;
        r_e_half <= r_half;
        r_e_vld  <= 1'b1;
        r_half   <= ~r_half;
      end
    end
  end

  assign tx_loc_bocE = r_e;
  assign tx_loc_bocP = r_p;
  assign tx_loc_bocL = r_l;
  assign tx_prn_sop  = r_sop;
  assign tx_chip_idx = r_p_idx;

endmodule
`default_nettype wire

// File: tb/tb_b1_code_gen.sv
`default_nettype none
// ============================================================
// Module  : tb_b1_code_gen
// Brief   : Scoreboard bench for b1_code_gen against a cycle model.
// Rev     : 1.0
// ============================================================
module tb_b1_code_gen;

`ifdef B1_BOC_SUBCARRIER_EN
  localparam bit c_boc = 1'b1;
`else
  localparam bit c_boc = 1'b0;
`endif
  localparam int c_len = 2046;

  logic        rx_clk = 1'b0;
  logic        rx_rst;
  logic        rx_en;
  logic [31:0] rx_prn_fcw;
  logic [3:0]  rx_g2_tap1;
  logic [3:0]  rx_g2_tap2;
  logic        tx_loc_bocE;
  logic        tx_loc_bocP;
  logic        tx_loc_bocL;
  logic        tx_prn_sop;
  logic [10:0] tx_chip_idx;

  always #5 rx_clk = ~rx_clk;

  b1_code_gen dut (
    .rx_clk      (rx_clk),
    .rx_rst      (rx_rst),
    .rx_en       (rx_en),
    .rx_prn_fcw  (rx_prn_fcw),
    .rx_g2_tap1  (rx_g2_tap1),
    .rx_g2_tap2  (rx_g2_tap2),
    .tx_loc_bocE (tx_loc_bocE),
    .tx_loc_bocP (tx_loc_bocP),
    .tx_loc_bocL (tx_loc_bocL),
    .tx_prn_sop  (tx_prn_sop),
    .tx_chip_idx (tx_chip_idx)
  );

  int n_vec = 0;
  int n_err = 0;
  bit abort = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      if (n_err > 50) abort = 1'b1;
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_acc;
  logic        m_half, m_tick, m_lock;
  logic [11:1] m_g1, m_g2;
  logic [3:0]  m_t1, m_t2;
  logic [10:0] m_chip, m_eidx, m_pidx;
  logic        m_e, m_p, m_l, m_sop, m_eh, m_ph, m_evld, m_pvld;

  function automatic logic stage(input logic [11:1] g, input logic [3:0] t);
    return (t >= 4'd1 && t <= 4'd11) ? g[t] : 1'b0;
  endfunction

  task automatic model_reset();
    m_acc = '0; m_half = 0; m_tick = 0; m_lock = 0;
    m_g1 = 11'b01010101010; m_g2 = 11'b01010101010;
    m_t1 = 0; m_t2 = 0; m_chip = 0; m_eidx = 0; m_pidx = 0;
    m_e = 0; m_p = 0; m_l = 0; m_sop = 0; m_eh = 0; m_ph = 0; m_evld = 0; m_pvld = 0;
  endtask

  task automatic model_edge();
    logic [32:0] sum;
    logic        c, upd, fb1, fb2, sop_n;
    if (rx_rst) begin model_reset(); return; end
    sum    = {1'b0, m_acc} + {1'b0, rx_prn_fcw};
    m_tick = rx_en && sum[32];
    if (rx_en) m_acc = sum[31:0];
    c      = m_g1[11] ^ stage(m_g2, m_t1) ^ stage(m_g2, m_t2);
    upd    = !m_lock || (m_tick && m_half);
    sop_n  = 1'b0;
    if (m_tick) begin
      sop_n = m_evld && (m_eidx == 0) && !m_eh;
      m_l = m_p; m_p = m_e; m_e = c ^ (c_boc & m_half);
      m_pidx = m_eidx; m_ph = m_eh; m_pvld = m_evld;
      m_eidx = m_chip; m_eh = m_half; m_evld = 1'b1; m_lock = 1'b1;
      if (m_half) begin
        if (m_chip == 11'(c_len - 1)) begin
          m_g1 = 11'b01010101010; m_g2 = 11'b01010101010; m_chip = 0;
        end else begin
          fb1 = m_g1[1] ^ m_g1[7] ^ m_g1[8] ^ m_g1[9] ^ m_g1[10] ^ m_g1[11];
          fb2 = m_g2[1] ^ m_g2[2] ^ m_g2[3] ^ m_g2[4] ^ m_g2[5] ^ m_g2[8] ^ m_g2[9] ^ m_g2[11];
          m_g1 = {m_g1[10:1], fb1}; m_g2 = {m_g2[10:1], fb2};
          m_chip = m_chip + 1;
        end
      end
      m_half = !m_half;
    end
    m_sop = sop_n;
    if (upd) begin m_t1 = rx_g2_tap1; m_t2 = rx_g2_tap2; end
  endtask

  // Golden taps-1/3 chip sequence, built independently of the cycle model.
  logic gold [0:31];
  task automatic gen_gold();
    logic [11:1] a, b;
    logic fa, fb;
    a = 11'b01010101010; b = 11'b01010101010;
    for (int i = 0; i < 32; i++) begin
      gold[i] = a[11] ^ b[1] ^ b[3];
      fa = a[1] ^ a[7] ^ a[8] ^ a[9] ^ a[10] ^ a[11];
      fb = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[8] ^ b[9] ^ b[11];
      a = {a[10:1], fa}; b = {b[10:1], fb};
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        e, p, l, sop;
    logic [10:0] idx;
  } exp_t;
  exp_t sb_q[$];

  int   cyc = 0;
  bit   win = 0, per_chk = 0, rst_watch = 0, meas = 0;
  int   last_sop = -1, sops_seen = 0, ticks_since = 0, last_chg = -1;
  logic [10:0] last_idx = 0;
  logic ehist[$];

  task automatic step();
    exp_t x;
    model_edge();
    sb_q.push_back('{m_e, m_p, m_l, m_sop, m_pidx});
    @(posedge rx_clk);
    #1;
    cyc++;
    x = sb_q.pop_front();
    chk("outputs", {tx_loc_bocE, tx_loc_bocP, tx_loc_bocL, tx_prn_sop, tx_chip_idx}, x);
    if (m_tick) begin
      ticks_since++;
      ehist.push_back(m_e);
      if (win) begin
        if (ehist.size() >= 3) chk("L_is_E_2ticks", tx_loc_bocL, ehist[ehist.size()-3]);
        if (m_pvld) chk("P_golden", tx_loc_bocP, gold[m_pidx[4:0]] ^ (c_boc & m_ph));
        if (m_pvld && m_ph) chk("P_half_pair", tx_loc_bocP, m_l ^ c_boc);
      end
    end
    if (tx_prn_sop) begin
      sops_seen++;
      if (per_chk && last_sop >= 0) chk("sop_period", cyc - last_sop, 8184);
      last_sop = cyc;
      if (rst_watch) begin
        chk("sop_2nd_tick", ticks_since, 2);
        rst_watch = 0;
      end
    end
    if (meas && tx_chip_idx != last_idx) begin
      if (last_chg >= 0) chk("chip_period", cyc - last_chg, 8);
      last_chg = cyc;
    end
    last_idx = tx_chip_idx;
  endtask

  initial begin
    gen_gold();
    model_reset();
    rx_rst = 1; rx_en = 1; rx_prn_fcw = 32'h8000_0000;
    rx_g2_tap1 = 4'd1; rx_g2_tap2 = 4'd3;
    step(); step();
    chk("reset_outputs", {tx_loc_bocE, tx_loc_bocP, tx_loc_bocL, tx_prn_sop, tx_chip_idx}, 0);
    rx_rst = 0; ticks_since = 0; rst_watch = 1;

    // Nominal rate: golden chips, spacing, and two full code periods.
    win = 1; per_chk = 1;
    for (int i = 0; i < 2 * 8184 + 20 && !abort; i++) begin
      if (i == 80) win = 0;
      step();
    end
    per_chk = 0;
    chk("sop_count_2per", sops_seen, 3);

    // Zero FCW: nothing moves.
    rx_prn_fcw = 32'h0; sops_seen = 0;
    for (int i = 0; i < 1000 && !abort; i++) step();
    chk("fcw0_no_sop", sops_seen, 0);

    // Asynchronous reset at chip 1000.
    rx_prn_fcw = 32'h8000_0000;
    for (int i = 0; i < 5000 && !abort && m_chip != 11'd1000; i++) step();
    #2 rx_rst = 1;
    #1 chk("async_rst", {tx_loc_bocE, tx_loc_bocP, tx_loc_bocL, tx_prn_sop, tx_chip_idx}, 0);
    model_reset();
    step(); step();
    rx_rst = 0; ticks_since = 0; rst_watch = 1;
    for (int i = 0; i < 20 && !abort; i++) step();
    chk("sop_after_rst", rst_watch, 0);

    // Mid-chip tap change, FCW halving, and an enable hold.
    for (int i = 0; i < 4 && !abort && m_half != 1'b1; i++) step();
    rx_g2_tap1 = 4'd2; rx_g2_tap2 = 4'd7;
    rx_prn_fcw = 32'h4000_0000;
    for (int i = 0; i < 40 && !abort; i++) step();
    meas = 1; last_chg = -1;
    for (int i = 0; i < 40 && !abort; i++) step();
    meas = 0;
    rx_en = 0;
    for (int i = 0; i < 10 && !abort; i++) step();
    rx_en = 1;
    for (int i = 0; i < 40 && !abort; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
